// File: rtl/register_dump_tx.sv
// -----------------------------------------------------------------------------
// register_dump_tx
//
// Streams a snapshot of a flat register-file image out of a byte-wide
// valid/ready port. A dump starts with the header byte 8'h52 and continues
// with every register, register 0 first and the most-significant byte of each
// register first. When the last byte has been accepted, done pulses for one
// cycle and the block returns to IDLE.
//
// Ports
//   clk        single clock, all state changes on posedge
//   reset      asynchronous, active-low reset
//   start      request a dump (sampled only in IDLE)
//   registers  flat register image, register 0 in the top DATA_WIDTH bits
//   tx_data    byte offered to the serial transmitter (registered)
//   tx_valid   tx_data is valid (registered)
//   tx_ready   transmitter accepts tx_data on this edge
//   busy       dump in progress: HEADER, SEND or DONE (registered)
//   done       one-cycle pulse in the DONE state (registered)
// -----------------------------------------------------------------------------
module register_dump_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] registers,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int TOTAL_BITS = DATA_WIDTH * NUM_REGS;
  localparam int NUM_BYTES  = TOTAL_BITS / 8;
  localparam int CNT_W      = $clog2(NUM_BYTES);

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_BYTES - 1);
  localparam logic [7:0]       HEADER_BYTE = 8'h52;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    SEND,
    DONE
  } state_t;

  state_t                r_state;
  logic [TOTAL_BITS-1:0] r_snap;
  logic [CNT_W-1:0]      r_cnt;   // index of the payload byte on tx_data
  logic [7:0]            w_snap_top;

  // The snapshot is consumed as a shift register: its top byte is always the
  // next payload byte to present, so no wide variable-index mux is needed.
  // Because the register image is laid out MSB-first, shifting left by one
  // byte walks through registers 0..N-1, most-significant byte first.
  assign w_snap_top = r_snap[TOTAL_BITS-1 -: 8];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      // NOTE: the snapshot buffer is an ordinary register bank, not a RAM, so
      // it is cleared on reset like the rest of the state; nothing stale can
      // leak into a later dump.
      r_snap   <= '0;
      r_cnt    <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_snap   <= registers;
            r_cnt    <= '0;
            tx_data  <= HEADER_BYTE;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            r_state  <= HEADER;
          end
        end

        HEADER: begin
          // Header accepted: present payload byte 0 immediately.
          if (tx_ready) begin
            tx_data <= w_snap_top;
            r_snap  <= {r_snap[TOTAL_BITS-9:0], 8'h00};
            r_state <= SEND;
          end
        end

        SEND: begin
          if (tx_ready) begin
            if (r_cnt == LAST_IDX) begin
              // Last byte accepted: stop offering data, counter stays put.
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              done     <= 1'b1;
              r_state  <= DONE;
            end else begin
              tx_data <= w_snap_top;
              r_snap  <= {r_snap[TOTAL_BITS-9:0], 8'h00};
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state  <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_tx.sv
// -----------------------------------------------------------------------------
// tb_register_dump_tx
//
// Self-checking bench for register_dump_tx. A negedge monitor drives tx_ready,
// pops the expected byte stream from a scoreboard queue on every transfer and
// checks that stalled data holds. Scenario tasks run from a single initial
// block and check timing and control outputs at negedge + 1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_register_dump_tx;

  localparam int DW      = 32;
  localparam int NR      = 32;
  localparam int NBYTES  = DW * NR / 8;
  localparam int LOG_SZ  = 4096;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [DW*NR-1:0]   registers;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b1;
  logic               busy;
  logic               done;

  register_dump_tx #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .registers (registers),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int pe = 0;                 // posedges seen so far
  always @(posedge clk) pe <= pe + 1;

  logic [DW-1:0] reg_val [NR];
  logic [7:0]    exp_q [$];
  logic [7:0]    rx_log [LOG_SZ];
  int            tot_xfer   = 0;
  int            done_cnt   = 0;
  int            done_pe    = 0;
  bit            ready_mode = 1'b0;  // 0: always ready, 1: ~30% ready
  bit            prev_stall = 1'b0;
  logic [7:0]    prev_data  = 8'h00;

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard: runs at negedge; the tx_ready it picks applies to the
  // following posedge, so a transfer is logged here when valid and ready.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_stall = 1'b0;
      tx_ready   = 1'b1;
    end else begin
      if (prev_stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required tx_valid=1 tx_data=%h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_pe = pe;
      end
      tx_ready = ready_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (tx_valid === 1'b1 && tx_ready) begin
        rx_log[tot_xfer % LOG_SZ] = tx_data;
        tot_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h, required no transfer", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL byte_seq: got %h, required %h (transfer %0d)", tx_data, e, tot_xfer);
          end
        end
      end
      prev_stall = (tx_valid === 1'b1) && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_regs();
    for (int i = 0; i < NR; i++) registers[(NR-1-i)*DW +: DW] = reg_val[i];
  endtask

  task automatic set_pattern_index();
    for (int i = 0; i < NR; i++) reg_val[i] = 32'h0101_0101 * i;
    apply_regs();
  endtask

  task automatic set_pattern_random();
    for (int i = 0; i < NR; i++) reg_val[i] = $urandom;
    apply_regs();
  endtask

  // Expected stream: header then register k>>2, byte k[1:0], MSB first.
  task automatic push_dump();
    exp_q.push_back(8'h52);
    for (int k = 0; k < NBYTES; k++) begin
      logic [DW-1:0] w;
      w = reg_val[k / 4];
      exp_q.push_back(w[(3 - (k % 4)) * 8 +: 8]);
    end
  endtask

  // Pulses start for one cycle; n is the posedge index that samples it.
  // Returns at negedge+1 of the cycle right after that edge.
  task automatic start_dump(output int n);
    tick();
    start = 1'b1;
    n = pe + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int base;
    base = done_cnt;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_xfer(input int base, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tot_xfer - base >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    set_pattern_index();
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h busy=%b done=%b, required 0 00 0 0",
               tx_valid, tx_data, busy, done);
    end
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b busy=%b dones=%0d, required 0 0 0",
               tx_valid, busy, done_cnt);
    end
  endtask

  task automatic test_basic();
    int n, base;
    bit ok;
    set_pattern_index();
    base = tot_xfer;
    push_dump();
    start_dump(n);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h52 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_header: valid=%b data=%h busy=%b, required 1 52 1",
               tx_valid, tx_data, busy);
    end
    wait_done(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done_timeout: no done pulse, required one");
    end
    // done is high in cycle N+130, i.e. right after posedge N+129.
    checks++;
    if (done_pe - n != 129) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d edges after start, required 129", done_pe - n);
    end
    checks++;
    if (rx_log[(base+1)%LOG_SZ] !== 8'h00 || rx_log[(base+4)%LOG_SZ] !== 8'h00 ||
        rx_log[(base+5)%LOG_SZ] !== 8'h01 || rx_log[(base+8)%LOG_SZ] !== 8'h01) begin
      errors++;
      $display("FAIL basic_bytes_1_8: got %h %h %h %h, required 00 00 01 01",
               rx_log[(base+1)%LOG_SZ], rx_log[(base+4)%LOG_SZ],
               rx_log[(base+5)%LOG_SZ], rx_log[(base+8)%LOG_SZ]);
    end
    checks++;
    if (rx_log[(base+128)%LOG_SZ] !== 8'h1F || tot_xfer - base != 129) begin
      errors++;
      $display("FAIL basic_last_byte: got %h after %0d transfers, required 1f after 129",
               rx_log[(base+128)%LOG_SZ], tot_xfer - base);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_back_to_idle: done=%b busy=%b valid=%b, required 0 0 0",
               done, busy, tx_valid);
    end
  endtask

  task automatic test_backpressure();
    int n, base;
    bit ok;
    set_pattern_index();
    base = tot_xfer;
    ready_mode = 1'b1;
    push_dump();
    start_dump(n);
    wait_done(3000, ok);
    ready_mode = 1'b0;
    checks++;
    if (!ok || exp_q.size() != 0 || tot_xfer - base != 129) begin
      errors++;
      $display("FAIL bp_sequence: done=%b left=%0d transfers=%0d, required 1 0 129",
               ok, exp_q.size(), tot_xfer - base);
    end
    tick();
  endtask

  task automatic test_snapshot();
    int n;
    bit ok;
    set_pattern_random();
    push_dump();
    start_dump(n);
    registers = '1;   // one cycle after start
    wait_done(400, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL snapshot_isolation: done=%b left=%0d, required 1 0", ok, exp_q.size());
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int n, base, dbase;
    bit ok;
    set_pattern_random();
    base  = tot_xfer;
    dbase = done_cnt;
    push_dump();
    start_dump(n);
    wait_xfer(base, 41, ok);   // payload byte 40 now on tx_data
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, ok);
    repeat (20) tick();
    checks++;
    if (done_cnt - dbase != 1 || exp_q.size() != 0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: dones=%0d left=%0d valid=%b busy=%b, required 1 0 0 0",
               done_cnt - dbase, exp_q.size(), tx_valid, busy);
    end
  endtask

  task automatic test_reset_mid_dump();
    int n, base, dbase;
    bit ok;
    set_pattern_random();
    base = tot_xfer;
    push_dump();
    start_dump(n);
    wait_xfer(base, 61, ok);   // payload byte 60 now on tx_data
    checks++;
    if (!ok || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach: reached=%b valid=%b, required 1 1", ok, tx_valid);
    end
    #1 reset = 1'b0;           // between edges
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b busy=%b done=%b, required 0 0 0",
               tx_valid, busy, done);
    end
    exp_q.delete();
    dbase = done_cnt;
    tick();
    tick();
    reset = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_cnt != dbase || tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: dones=%0d valid=%b busy=%b, required 0 0 0",
               done_cnt - dbase, tx_valid, busy);
    end
    base = tot_xfer;
    push_dump();
    start_dump(n);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h52) begin
      errors++;
      $display("FAIL reset_restart_header: valid=%b data=%h, required 1 52", tx_valid, tx_data);
    end
    wait_done(400, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || rx_log[(base+1)%LOG_SZ] !== reg_val[0][31:24]) begin
      errors++;
      $display("FAIL reset_restart_dump: done=%b left=%0d byte0=%h, required 1 0 %h",
               ok, exp_q.size(), rx_log[(base+1)%LOG_SZ], reg_val[0][31:24]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int d1;
    bit ok;
    set_pattern_random();
    push_dump();
    push_dump();
    tick();
    start = 1'b1;
    wait_done(400, ok);
    d1 = done_pe;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_first_done: no done pulse, required one");
    end
    tick();                    // IDLE cycle
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || pe - d1 != 1) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b valid=%b edge=%0d, required 0 0 1", busy, tx_valid, pe - d1);
    end
    tick();                    // second header
    start = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h52 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_header: valid=%b data=%h busy=%b, required 1 52 1",
               tx_valid, tx_data, busy);
    end
    wait_done(400, ok);
    repeat (5) tick();
    checks++;
    if (!ok || exp_q.size() != 0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_dump: done=%b left=%0d valid=%b, required 1 0 0",
               ok, exp_q.size(), tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_ignored_start();
    test_reset_mid_dump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
